// File: rtl/riscv_pkg.sv
// Shared RV32I encodings, ALU-select codes and the ID/EX payload.
// Imported by the decode stage, its forwarding muxes and the ALU.
package riscv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_NOR  = 3'b101,
        ALU_SLT  = 3'b110,
        ALU_ZERO = 3'b111
    } alu_sel_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_sel_e              alu_sel;
        logic [XLEN-1:0]       alu_a;
        logic [XLEN-1:0]       alu_b;
        logic [XLEN-1:0]       store_data;
        logic [XLEN-1:0]       pc;
        logic [REG_AW-1:0]     rd;
        logic                  reg_wen;
        logic                  mem_read;
        logic                  mem_write;
        logic                  branch;
        logic                  illegal;
    } ex_payload_t;

    localparam ex_payload_t PAYLOAD_RST = '{alu_sel: ALU_ZERO, default: '0};

    // Shared funct3 map for OP and OP-IMM; shifts and SLTU(I) map to ALU_ZERO.
    function automatic alu_sel_e f3_to_alu(input logic [2:0] f3);
        case (f3)
            F3_ADD:  return ALU_ADD;
            F3_AND:  return ALU_AND;
            F3_OR:   return ALU_OR;
            F3_XOR:  return ALU_XOR;
            F3_SLT:  return ALU_SLT;
            default: return ALU_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass for one source register: EX/MEM beats MEM/WB beats the register file.
module fwd_mux
    import riscv_pkg::*;
(
    input  logic [REG_AW-1:0] rs_idx,
    input  logic [XLEN-1:0]   rf_data,
    input  logic              exm_wen,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [XLEN-1:0]   exm_data,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   fwd_data_c
);

    always_comb begin
        fwd_data_c = rf_data;
        if (rs_idx == '0) begin
            fwd_data_c = '0;
        end else if (exm_wen && (exm_rd == rs_idx)) begin
            fwd_data_c = exm_data;
        end else if (wb_wen && (wb_rd == rs_idx)) begin
            fwd_data_c = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes RV32I, forwards operands and holds the
// result behind a valid/ready handshake.
module id_ex_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        exm_wen,
    input  logic [4:0]  exm_rd,
    input  logic [31:0] exm_data,
    input  logic        wb_wen,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  alu_sel,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [31:0] store_data,
    output logic [31:0] pc_out,
    output logic [4:0]  rd,
    output logic        reg_wen,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic        illegal
);

    logic [XLEN-1:0] rs1_fwd_c;
    logic [XLEN-1:0] rs2_fwd_c;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic            xfer_c;
    logic            out_valid_q;
    ex_payload_t     dec_c;
    ex_payload_t     payload_q;

    fwd_mux u_fwd_rs1 (
        .rs_idx     (instr[19:15]),
        .rf_data    (rs1_data),
        .exm_wen    (exm_wen),
        .exm_rd     (exm_rd),
        .exm_data   (exm_data),
        .wb_wen     (wb_wen),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .fwd_data_c (rs1_fwd_c)
    );

    fwd_mux u_fwd_rs2 (
        .rs_idx     (instr[24:20]),
        .rf_data    (rs2_data),
        .exm_wen    (exm_wen),
        .exm_rd     (exm_rd),
        .exm_data   (exm_data),
        .wb_wen     (wb_wen),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .fwd_data_c (rs2_fwd_c)
    );

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'h000};

    assign in_ready = !out_valid_q || out_ready;
    assign xfer_c   = in_valid && in_ready && !flush;

    // Decode; every legal path sets a non-ZERO select, so ALU_ZERO marks illegal.
    always_comb begin
        dec_c            = PAYLOAD_RST;
        dec_c.alu_a      = rs1_fwd_c;
        dec_c.store_data = rs2_fwd_c;
        dec_c.pc         = pc;
        dec_c.rd         = instr[11:7];
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    dec_c.alu_sel = f3_to_alu(funct3);
                end else if ((funct7 == F7_ALT) && (funct3 == F3_ADD)) begin
                    dec_c.alu_sel = ALU_SUB;
                end
                dec_c.alu_b   = rs2_fwd_c;
                dec_c.reg_wen = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_c.alu_sel = f3_to_alu(funct3);
                dec_c.alu_b   = imm_i;
                dec_c.reg_wen = 1'b1;
            end
            OPC_LOAD: begin
                if (funct3 == F3_LW) begin
                    dec_c.alu_sel  = ALU_ADD;
                    dec_c.alu_b    = imm_i;
                    dec_c.mem_read = 1'b1;
                    dec_c.reg_wen  = 1'b1;
                end
            end
            OPC_STORE: begin
                if (funct3 == F3_SW) begin
                    dec_c.alu_sel   = ALU_ADD;
                    dec_c.alu_b     = imm_s;
                    dec_c.mem_write = 1'b1;
                end
            end
            OPC_BRANCH: begin
                if ((funct3 == F3_BEQ) || (funct3 == F3_BNE)) begin
                    dec_c.alu_sel = ALU_SUB;
                    dec_c.alu_b   = rs2_fwd_c;
                    dec_c.branch  = 1'b1;
                end
            end
            OPC_LUI: begin
                dec_c.alu_sel = ALU_ADD;
                dec_c.alu_a   = '0;
                dec_c.alu_b   = imm_u;
                dec_c.reg_wen = 1'b1;
            end
            OPC_AUIPC: begin
                dec_c.alu_sel = ALU_ADD;
                dec_c.alu_a   = pc;
                dec_c.alu_b   = imm_u;
                dec_c.reg_wen = 1'b1;
            end
            default: ;
        endcase
        if (dec_c.alu_sel == ALU_ZERO) begin
            dec_c.alu_a      = '0;
            dec_c.alu_b      = '0;
            dec_c.store_data = '0;
            dec_c.reg_wen    = 1'b0;
            dec_c.mem_read   = 1'b0;
            dec_c.mem_write  = 1'b0;
            dec_c.branch     = 1'b0;
            dec_c.illegal    = 1'b1;
        end
        if (dec_c.rd == '0) begin
            dec_c.reg_wen = 1'b0;
        end
    end

    // Payload only loads on transfer, so stalled entries keep their forwarded values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            payload_q   <= PAYLOAD_RST;
        end else begin
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (xfer_c) begin
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (xfer_c) begin
                payload_q <= dec_c;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign alu_sel    = payload_q.alu_sel;
    assign alu_a      = payload_q.alu_a;
    assign alu_b      = payload_q.alu_b;
    assign store_data = payload_q.store_data;
    assign pc_out     = payload_q.pc;
    assign rd         = payload_q.rd;
    assign reg_wen    = payload_q.reg_wen;
    assign mem_read   = payload_q.mem_read;
    assign mem_write  = payload_q.mem_write;
    assign branch     = payload_q.branch;
    assign illegal    = payload_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference decoder pushes expected
// payloads on transfer; the held entry is compared every cycle it is valid.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        exm_wen;
    logic [4:0]  exm_rd;
    logic [31:0] exm_data;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  alu_sel;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] store_data;
    logic [31:0] pc_out;
    logic [4:0]  rd;
    logic        reg_wen;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        illegal;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_data(exm_data),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .alu_sel(alu_sel),
        .alu_a(alu_a), .alu_b(alu_b), .store_data(store_data), .pc_out(pc_out),
        .rd(rd), .reg_wen(reg_wen), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [31:0] pcv;
        logic [4:0]  rd;
        logic        wen;
        logic        mr;
        logic        mw;
        logic        br;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    logic        m_valid;
    int          n_checks = 0;
    int          n_fail   = 0;
    string       phase    = "init";
    logic [31:0] prog[20];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL [%s] %s: got=%h expected=%h", phase, tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rdi);
        return {f7, rs2, rs1, f3, rdi, 7'h33};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rdi,
                                           input logic [6:0] op);
        return {imm, rs1, f3, rdi, op};
    endfunction

    function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] b_type(input logic [12:0] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] rf);
        if (r == 5'd0) return 32'd0;
        if (exm_wen && exm_rd == r) return exm_data;
        if (wb_wen && wb_rd == r) return wb_data;
        return rf;
    endfunction

    // Reference decoder written from the instruction list.
    function automatic exp_t m_decode(input logic [31:0] ins);
        exp_t        e;
        logic [2:0]  s;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ii;
        logic [31:0] si;
        logic [31:0] ui;
        f3 = ins[14:12];
        f7 = ins[31:25];
        a  = m_fwd(ins[19:15], rs1_data);
        b  = m_fwd(ins[24:20], rs2_data);
        ii = {{20{ins[31]}}, ins[31:20]};
        si = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ui = {ins[31:12], 12'h000};
        s  = 3'd7;
        e  = '{sel: 3'd7, a: 32'd0, b: 32'd0, sd: 32'd0, pcv: pc, rd: ins[11:7],
               wen: 1'b0, mr: 1'b0, mw: 1'b0, br: 1'b0, ill: 1'b1};
        case (ins[6:0])
            7'h33: begin
                e.a = a; e.b = b; e.wen = 1'b1;
                if (f7 == 7'h00) begin
                    if (f3 == 3'd0) s = 3'd0;
                    if (f3 == 3'd7) s = 3'd2;
                    if (f3 == 3'd6) s = 3'd3;
                    if (f3 == 3'd4) s = 3'd4;
                    if (f3 == 3'd2) s = 3'd6;
                end else if (f7 == 7'h20 && f3 == 3'd0) begin
                    s = 3'd1;
                end
            end
            7'h13: begin
                e.a = a; e.b = ii; e.wen = 1'b1;
                if (f3 == 3'd0) s = 3'd0;
                if (f3 == 3'd7) s = 3'd2;
                if (f3 == 3'd6) s = 3'd3;
                if (f3 == 3'd4) s = 3'd4;
                if (f3 == 3'd2) s = 3'd6;
            end
            7'h03: if (f3 == 3'd2) begin
                s = 3'd0; e.a = a; e.b = ii; e.mr = 1'b1; e.wen = 1'b1;
            end
            7'h23: if (f3 == 3'd2) begin
                s = 3'd0; e.a = a; e.b = si; e.mw = 1'b1; e.sd = b;
            end
            7'h63: if (f3 == 3'd0 || f3 == 3'd1) begin
                s = 3'd1; e.a = a; e.b = b; e.br = 1'b1;
            end
            7'h37: begin s = 3'd0; e.a = 32'd0; e.b = ui; e.wen = 1'b1; end
            7'h17: begin s = 3'd0; e.a = pc;    e.b = ui; e.wen = 1'b1; end
            default: ;
        endcase
        if (s == 3'd7) begin
            e = '{sel: 3'd7, a: 32'd0, b: 32'd0, sd: 32'd0, pcv: pc, rd: ins[11:7],
                  wen: 1'b0, mr: 1'b0, mw: 1'b0, br: 1'b0, ill: 1'b1};
        end else begin
            e.sel = s;
            e.ill = 1'b0;
        end
        if (ins[11:7] == 5'd0) e.wen = 1'b0;
        return e;
    endfunction

    task automatic check_outputs();
        exp_t e;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid && sb.size() > 0) begin
            e = sb[0];
            check("alu_sel",   32'(alu_sel),   32'(e.sel));
            check("rd",        32'(rd),        32'(e.rd));
            check("reg_wen",   32'(reg_wen),   32'(e.wen));
            check("mem_read",  32'(mem_read),  32'(e.mr));
            check("mem_write", 32'(mem_write), 32'(e.mw));
            check("branch",    32'(branch),    32'(e.br));
            check("illegal",   32'(illegal),   32'(e.ill));
            check("pc_out",    pc_out,         e.pcv);
            if (!e.ill) begin
                check("alu_a", alu_a, e.a);
                check("alu_b", alu_b, e.b);
            end
            if (e.mw) check("store_data", store_data, e.sd);
        end
    endtask

    task automatic check_reset_vals();
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst alu_sel",   32'(alu_sel),   32'd7);
        check("rst alu_a",     alu_a,          32'd0);
        check("rst alu_b",     alu_b,          32'd0);
        check("rst store",     store_data,     32'd0);
        check("rst pc_out",    pc_out,         32'd0);
        check("rst rd",        32'(rd),        32'd0);
        check("rst ctrl",      32'({reg_wen, mem_read, mem_write, branch, illegal}), 32'd0);
    endtask

    // One clock: inputs are already set by the caller at posedge+1.
    task automatic cycle();
        logic exp_rdy;
        logic xfer;
        exp_t e;
        #1;
        exp_rdy = !m_valid || out_ready;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        xfer = in_valid && exp_rdy && !flush;
        if (xfer) e = m_decode(instr);
        @(posedge clk);
        if ((flush || (m_valid && out_ready)) && sb.size() > 0) void'(sb.pop_front());
        if (flush) m_valid = 1'b0;
        else if (xfer) begin m_valid = 1'b1; sb.push_back(e); end
        else if (out_ready) m_valid = 1'b0;
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                         input logic [31:0] r2, input logic ordy);
        in_valid  = v;
        instr     = ins;
        rs1_data  = r1;
        rs2_data  = r2;
        out_ready = ordy;
        pc        = pc + 32'd4;
    endtask

    task automatic clear_fwd();
        exm_wen = 1'b0; exm_rd = 5'd0; exm_data = 32'd0;
        wb_wen  = 1'b0; wb_rd  = 5'd0; wb_data  = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; instr = 32'd0; pc = 32'h1000;
        rs1_data = 32'd0; rs2_data = 32'd0; flush = 1'b0; out_ready = 1'b0;
        clear_fwd();
        m_valid = 1'b0;
        prog[0]  = i_type(12'hFFC, 5'd2, 3'd2, 5'd5, 7'h03);            // lw
        prog[1]  = b_type(13'h010, 5'd2, 5'd1, 3'd0);                   // beq
        prog[2]  = b_type(13'h1FF0, 5'd3, 5'd1, 3'd1);                  // bne
        prog[3]  = {20'hABCDE, 5'd7, 7'h37};                            // lui
        prog[4]  = {20'h80001, 5'd8, 7'h17};                            // auipc
        prog[5]  = i_type(12'h800, 5'd1, 3'd6, 5'd9, 7'h13);            // ori
        prog[6]  = i_type(12'h0F0, 5'd2, 3'd4, 5'd10, 7'h13);           // xori
        prog[7]  = i_type(12'h7FF, 5'd3, 3'd7, 5'd11, 7'h13);           // andi
        prog[8]  = i_type(12'hFFF, 5'd1, 3'd2, 5'd12, 7'h13);           // slti
        prog[9]  = r_type(7'h00, 5'd2, 5'd1, 3'd2, 5'd13);              // slt
        prog[10] = r_type(7'h00, 5'd3, 5'd2, 3'd4, 5'd14);              // xor
        prog[11] = r_type(7'h00, 5'd1, 5'd3, 3'd6, 5'd15);              // or
        prog[12] = r_type(7'h00, 5'd2, 5'd3, 3'd7, 5'd16);              // and
        prog[13] = r_type(7'h00, 5'd2, 5'd1, 3'd3, 5'd17);              // sltu
        prog[14] = i_type(12'h005, 5'd1, 3'd3, 5'd18, 7'h13);           // sltiu
        prog[15] = 32'h0000_0073;                                        // ecall
        prog[16] = {20'h00100, 5'd1, 7'h6F};                            // jal
        prog[17] = r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd0);               // add x0
        prog[18] = i_type(12'h004, 5'd1, 3'd0, 5'd4, 7'h03);            // lb
        prog[19] = s_type(12'h010, 5'd2, 5'd1, 3'd1);                   // sh

        repeat (2) @(posedge clk);
        #1;
        phase = "reset";
        check_reset_vals();
        check("rst in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        phase = "add";
        drive(1'b1, r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'd5, 32'd7, 1'b1);
        cycle();
        check("add alu_a", alu_a, 32'd5);
        check("add alu_b", alu_b, 32'd7);
        check("add rd", 32'(rd), 32'd3);
        in_valid = 1'b0;
        cycle();

        phase = "addi_x0";
        exm_wen = 1'b1; exm_rd = 5'd0; exm_data = 32'd9;
        drive(1'b1, i_type(12'hFFF, 5'd0, 3'd0, 5'd1, 7'h13), 32'd123, 32'd0, 1'b1);
        cycle();
        check("addi alu_a", alu_a, 32'd0);
        check("addi alu_b", alu_b, 32'hFFFF_FFFF);

        phase = "sub_fwd";
        exm_wen = 1'b1; exm_rd = 5'd1; exm_data = 32'd10;
        wb_wen  = 1'b1; wb_rd  = 5'd1; wb_data  = 32'd20;
        drive(1'b1, r_type(7'h20, 5'd1, 5'd1, 3'd0, 5'd4), 32'd99, 32'd99, 1'b1);
        cycle();
        check("sub alu_a", alu_a, 32'd10);
        check("sub alu_b", alu_b, 32'd10);
        check("sub sel", 32'(alu_sel), 32'd1);
        clear_fwd();

        phase = "sw_stall";
        drive(1'b1, s_type(12'd8, 5'd2, 5'd1, 3'd2), 32'd100, 32'h55, 1'b1);
        cycle();
        check("sw alu_b", alu_b, 32'd8);
        check("sw store", store_data, 32'h55);
        exm_wen = 1'b1; exm_rd = 5'd1; exm_data = 32'hDEAD;
        drive(1'b1, r_type(7'h00, 5'd7, 5'd6, 3'd7, 5'd5), 32'd1, 32'd2, 1'b0);
        repeat (3) cycle();
        check("stall alu_a", alu_a, 32'd100);
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        clear_fwd();

        phase = "flush";
        drive(1'b1, r_type(7'h00, 5'd2, 5'd1, 3'd6, 5'd6), 32'h0F, 32'hF0, 1'b1);
        cycle();
        drive(1'b1, r_type(7'h00, 5'd2, 5'd1, 3'd4, 5'd7), 32'd1, 32'd2, 1'b0);
        flush = 1'b1;
        cycle();
        out_ready = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        cycle();

        phase = "sll";
        drive(1'b1, r_type(7'h00, 5'd3, 5'd2, 3'd1, 5'd1), 32'd3, 32'd4, 1'b1);
        cycle();
        check("sll illegal", 32'(illegal), 32'd1);
        check("sll sel", 32'(alu_sel), 32'd7);

        phase = "stream";
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 20; i++) begin
                exm_wen = 1'($urandom_range(0, 1)); exm_rd = 5'($urandom_range(0, 3));
                exm_data = $urandom;
                wb_wen = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 3));
                wb_data = $urandom;
                flush = ($urandom_range(0, 15) == 0);
                drive(1'($urandom_range(0, 3) != 0), prog[i], $urandom, $urandom,
                      1'($urandom_range(0, 2) != 0));
                cycle();
            end
        end
        flush = 1'b0; clear_fwd();

        phase = "rst_stall";
        drive(1'b1, prog[0], 32'h2000, 32'd0, 1'b1);
        cycle();
        drive(1'b1, prog[3], 32'd0, 32'd0, 1'b0);
        cycle();
        rst = 1'b1;
        #1;
        check_reset_vals();
        check("rst in_ready", 32'(in_ready), 32'd1);
        m_valid = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        check_reset_vals();
        rst = 1'b0;
        drive(1'b1, r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'd40, 32'd2, 1'b1);
        cycle();
        check("post-rst alu_a", alu_a, 32'd40);
        in_valid = 1'b0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
